// File: rtl/batalha_naval_ctrl_pkg.sv
// Shared encodings for the battleship control core: FSM states, shot results
// and the mode codes coming from the switch decoder.
package batalha_pkg;

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    PREPARACAO = 3'd1,
    ATAQUE     = 3'd2,
    VITORIA    = 3'd3,
    DERROTA    = 3'd4
  } estado_t;

  typedef enum logic [1:0] {
    RES_NADA     = 2'b00,
    RES_AGUA     = 2'b01,
    RES_ACERTO   = 2'b10,
    RES_REPETIDO = 2'b11
  } resultado_t;

  localparam logic [1:0] MODO_OFF  = 2'b00;
  localparam logic [1:0] MODO_PREP = 2'b01;

  // Both 10 and 11 select attack mode, so only the upper bit matters.
  function automatic logic modo_ataque(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/batalha_naval_ctrl_contador_bits.sv
// Combinational population count of an N-bit vector, used to size the fleet
// when a candidate map is confirmed.
module contador_bits #(
  parameter int N     = 35,
  parameter int CNT_W = 6
) (
  input  logic [N-1:0]     vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/batalha_naval_ctrl.sv
// Battleship game FSM and datapath: map latch, shot tracking, hit/shot
// counters, win/lose detection and registered status LEDs.
module batalha_naval_ctrl
  import batalha_pkg::*;
#(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int MAX_SHOTS = 15,
  parameter int CNT_W     = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           modo,
  input  logic                 confirmar,
  input  logic [2:0]           linha,
  input  logic [2:0]           coluna,
  input  logic [ROWS*COLS-1:0] mapa_in,
  output logic [2:0]           estado,
  output logic                 mapa_ok,
  output logic [ROWS*COLS-1:0] tiros,
  output logic [ROWS*COLS-1:0] acertos_mapa,
  output logic [CNT_W-1:0]     restantes,
  output logic [CNT_W-1:0]     tiros_rest,
  output logic [CNT_W-1:0]     acertos,
  output logic [1:0]           resultado,
  output logic                 LED_R,
  output logic                 LED_G,
  output logic                 LED_B
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX_SHOTS);
  localparam bit LIMITADO = (MAX_SHOTS != 0);

  estado_t          state_q, state_d;
  resultado_t       res_q, res_d;
  logic             mapa_ok_q, mapa_ok_d;
  logic [N-1:0]     mapa_q, mapa_d;
  logic [N-1:0]     tiros_q, tiros_d;
  logic [CNT_W-1:0] restantes_q, restantes_d;
  logic [CNT_W-1:0] tiros_rest_q, tiros_rest_d;
  logic [CNT_W-1:0] acertos_q, acertos_d;
  logic             led_r_q, led_r_d;
  logic             led_g_q, led_g_d;
  logic             led_b_q, led_b_d;

  logic [CNT_W-1:0] pop_mapa;
  logic             coord_ok;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     alvo;
  logic             limpar;

  contador_bits #(.N(N), .CNT_W(CNT_W)) u_pop (
    .vec_i (mapa_in),
    .cnt_o (pop_mapa)
  );

  // alvo is only meaningful when coord_ok; out-of-grid indices are never used.
  always_comb begin
    coord_ok = (int'(linha) < ROWS) && (int'(coluna) < COLS);
    idx      = IDX_W'(int'(linha) * COLS + int'(coluna));
    alvo     = N'(1) << idx;
  end

  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    mapa_ok_d    = mapa_ok_q;
    mapa_d       = mapa_q;
    tiros_d      = tiros_q;
    restantes_d  = restantes_q;
    tiros_rest_d = tiros_rest_q;
    acertos_d    = acertos_q;
    limpar       = 1'b0;

    if (modo == MODO_OFF) begin
      limpar = 1'b1;
    end else begin
      case (state_q)
        DESLIGADO: state_d = PREPARACAO;
        PREPARACAO: begin
          if (modo_ataque(modo) && mapa_ok_q) begin
            state_d = ATAQUE;
          end else if (confirmar) begin
            if (pop_mapa != '0) begin
              mapa_d       = mapa_in;
              mapa_ok_d    = 1'b1;
              restantes_d  = pop_mapa;
              tiros_rest_d = MAX_Q;
              acertos_d    = '0;
              tiros_d      = '0;
              res_d        = RES_NADA;
            end else begin
              res_d = RES_REPETIDO;
            end
          end
        end
        ATAQUE: begin
          if (modo == MODO_PREP) begin
            state_d   = PREPARACAO;
            mapa_ok_d = 1'b0;
          end else if (confirmar) begin
            if (!coord_ok || ((tiros_q & alvo) != '0)) begin
              res_d = RES_REPETIDO;
            end else begin
              tiros_d = tiros_q | alvo;
              if (LIMITADO) tiros_rest_d = tiros_rest_q - CNT_W'(1);
              if ((mapa_q & alvo) != '0) begin
                acertos_d   = acertos_q + CNT_W'(1);
                restantes_d = restantes_q - CNT_W'(1);
                res_d       = RES_ACERTO;
              end else begin
                res_d = RES_AGUA;
              end
              // Sinking the last ship wins even if the budget ran out on this shot.
              if (restantes_d == '0) state_d = VITORIA;
              else if (LIMITADO && (tiros_rest_d == '0)) state_d = DERROTA;
            end
          end
        end
        VITORIA, DERROTA: begin
          if (modo == MODO_PREP) begin
            state_d   = PREPARACAO;
            mapa_ok_d = 1'b0;
          end
        end
        default: limpar = 1'b1;
      endcase
    end

    if (limpar) begin
      state_d      = DESLIGADO;
      res_d        = RES_NADA;
      mapa_ok_d    = 1'b0;
      mapa_d       = '0;
      tiros_d      = '0;
      restantes_d  = '0;
      tiros_rest_d = '0;
      acertos_d    = '0;
    end
  end

  // LEDs follow the next state so they change on the same edge as the game.
  always_comb begin
    led_r_d = 1'b0;
    led_g_d = 1'b0;
    led_b_d = 1'b0;
    case (state_d)
      PREPARACAO: led_b_d = mapa_ok_d;
      ATAQUE: begin
        case (res_d)
          RES_AGUA:     led_r_d = 1'b1;
          RES_ACERTO:   led_g_d = 1'b1;
          RES_REPETIDO: led_b_d = 1'b1;
          default:      ;
        endcase
      end
      VITORIA: led_g_d = 1'b1;
      DERROTA: led_r_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DESLIGADO;
      res_q        <= RES_NADA;
      mapa_ok_q    <= 1'b0;
      mapa_q       <= '0;
      tiros_q      <= '0;
      restantes_q  <= '0;
      tiros_rest_q <= '0;
      acertos_q    <= '0;
      led_r_q      <= 1'b0;
      led_g_q      <= 1'b0;
      led_b_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      mapa_ok_q    <= mapa_ok_d;
      mapa_q       <= mapa_d;
      tiros_q      <= tiros_d;
      restantes_q  <= restantes_d;
      tiros_rest_q <= tiros_rest_d;
      acertos_q    <= acertos_d;
      led_r_q      <= led_r_d;
      led_g_q      <= led_g_d;
      led_b_q      <= led_b_d;
    end
  end

  assign estado       = state_q;
  assign resultado    = res_q;
  assign mapa_ok      = mapa_ok_q;
  assign tiros        = tiros_q;
  assign acertos_mapa = tiros_q & mapa_q;
  assign restantes    = restantes_q;
  assign tiros_rest   = tiros_rest_q;
  assign acertos      = acertos_q;
  assign LED_R        = led_r_q;
  assign LED_G        = led_g_q;
  assign LED_B        = led_b_q;

endmodule

// File: tb/tb_batalha_naval_ctrl.sv
// Directed bench: a vector table drives the main game flow on the default
// instance, hand sequences cover shot budgets, win priority and async reset.
module tb_batalha_naval_ctrl;

  localparam int N = 35;
  localparam logic [N-1:0] MAP_A = 35'h0_0000_1041;
  localparam logic [N-1:0] MAP_B = 35'h4_0000_0000;
  localparam logic [N-1:0] MAP_C = 35'h0_0000_0003;
  localparam logic [N-1:0] ZERO  = '0;

  logic           clock;
  logic           reset_n;
  logic [1:0]     modo;
  logic           confirmar;
  logic [2:0]     linha;
  logic [2:0]     coluna;
  logic [N-1:0]   mapa_in;

  logic [2:0]   est0, est1, est2;
  logic         ok0, ok1, ok2;
  logic [N-1:0] tir0, tir1, tir2, am0, am1, am2;
  logic [5:0]   rest0, rest1, rest2, tr0, tr1, tr2, ac0, ac1, ac2;
  logic [1:0]   res0, res1, res2;
  logic         r0, g0, b0, r1, g1, b1, r2, g2, b2;

  int n_tests = 0;
  int n_fail  = 0;

  batalha_naval_ctrl #(.ROWS(7), .COLS(5), .MAX_SHOTS(15), .CNT_W(6)) dut0 (
    .clock(clock), .reset_n(reset_n), .modo(modo), .confirmar(confirmar),
    .linha(linha), .coluna(coluna), .mapa_in(mapa_in),
    .estado(est0), .mapa_ok(ok0), .tiros(tir0), .acertos_mapa(am0),
    .restantes(rest0), .tiros_rest(tr0), .acertos(ac0), .resultado(res0),
    .LED_R(r0), .LED_G(g0), .LED_B(b0));

  batalha_naval_ctrl #(.ROWS(7), .COLS(5), .MAX_SHOTS(2), .CNT_W(6)) dut1 (
    .clock(clock), .reset_n(reset_n), .modo(modo), .confirmar(confirmar),
    .linha(linha), .coluna(coluna), .mapa_in(mapa_in),
    .estado(est1), .mapa_ok(ok1), .tiros(tir1), .acertos_mapa(am1),
    .restantes(rest1), .tiros_rest(tr1), .acertos(ac1), .resultado(res1),
    .LED_R(r1), .LED_G(g1), .LED_B(b1));

  batalha_naval_ctrl #(.ROWS(7), .COLS(5), .MAX_SHOTS(0), .CNT_W(6)) dut2 (
    .clock(clock), .reset_n(reset_n), .modo(modo), .confirmar(confirmar),
    .linha(linha), .coluna(coluna), .mapa_in(mapa_in),
    .estado(est2), .mapa_ok(ok2), .tiros(tir2), .acertos_mapa(am2),
    .restantes(rest2), .tiros_rest(tr2), .acertos(ac2), .resultado(res2),
    .LED_R(r2), .LED_G(g2), .LED_B(b2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   modo;
    logic         conf;
    logic [2:0]   lin;
    logic [2:0]   col;
    logic [N-1:0] mapa;
    logic [2:0]   e_est;
    logic         e_ok;
    logic [5:0]   e_rest;
    logic [5:0]   e_trest;
    logic [5:0]   e_ac;
    logic [1:0]   e_res;
    logic [2:0]   e_rgb;
    logic [N-1:0] e_tiros;
    logic [N-1:0] e_am;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] m, input logic c, input logic [2:0] l,
                     input logic [2:0] co, input logic [N-1:0] mp,
                     input logic [2:0] est, input logic ok, input logic [5:0] rs,
                     input logic [5:0] tr, input logic [5:0] ac, input logic [1:0] re,
                     input logic [2:0] rgb, input logic [N-1:0] ti, input logic [N-1:0] am);
    vec_t v;
    v.modo = m; v.conf = c; v.lin = l; v.col = co; v.mapa = mp;
    v.e_est = est; v.e_ok = ok; v.e_rest = rs; v.e_trest = tr; v.e_ac = ac;
    v.e_res = re; v.e_rgb = rgb; v.e_tiros = ti; v.e_am = am;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] m, input logic c, input logic [2:0] l,
                      input logic [2:0] co, input logic [N-1:0] mp);
    modo = m; confirmar = c; linha = l; coluna = co; mapa_in = mp;
    @(posedge clock);
    #1;
    confirmar = 1'b0;
    $display("[TB] modo=%b conf=%b (%0d,%0d) -> estado=%0d/%0d/%0d res=%b rest=%0d trest=%0d/%0d/%0d",
             m, c, l, co, est0, est1, est2, res0, rest0, tr0, tr1, tr2);
  endtask

  initial begin
    reset_n = 1'b0; modo = 2'b00; confirmar = 1'b0;
    linha = '0; coluna = '0; mapa_in = '0;

    // modo, conf, lin, col, map | estado, ok, rest, trest, acertos, res, RGB, tiros, acertos_mapa
    add(2'b01, 1'b0, 3'd0, 3'd0, ZERO,  3'd1, 1'b0, 6'd0, 6'd0,  6'd0, 2'b00, 3'b000, 35'h0, 35'h0);
    add(2'b01, 1'b1, 3'd0, 3'd0, MAP_A, 3'd1, 1'b1, 6'd3, 6'd15, 6'd0, 2'b00, 3'b001, 35'h0, 35'h0);
    add(2'b10, 1'b0, 3'd0, 3'd0, MAP_A, 3'd2, 1'b1, 6'd3, 6'd15, 6'd0, 2'b00, 3'b000, 35'h0, 35'h0);
    add(2'b10, 1'b1, 3'd0, 3'd0, MAP_A, 3'd2, 1'b1, 6'd2, 6'd14, 6'd1, 2'b10, 3'b010, 35'h1, 35'h1);
    add(2'b10, 1'b1, 3'd0, 3'd1, MAP_A, 3'd2, 1'b1, 6'd2, 6'd13, 6'd1, 2'b01, 3'b100, 35'h3, 35'h1);
    add(2'b10, 1'b1, 3'd0, 3'd0, MAP_A, 3'd2, 1'b1, 6'd2, 6'd13, 6'd1, 2'b11, 3'b001, 35'h3, 35'h1);
    add(2'b10, 1'b1, 3'd7, 3'd0, MAP_A, 3'd2, 1'b1, 6'd2, 6'd13, 6'd1, 2'b11, 3'b001, 35'h3, 35'h1);
    add(2'b10, 1'b1, 3'd0, 3'd5, MAP_A, 3'd2, 1'b1, 6'd2, 6'd13, 6'd1, 2'b11, 3'b001, 35'h3, 35'h1);
    add(2'b10, 1'b0, 3'd0, 3'd0, MAP_A, 3'd2, 1'b1, 6'd2, 6'd13, 6'd1, 2'b11, 3'b001, 35'h3, 35'h1);
    add(2'b10, 1'b1, 3'd1, 3'd1, MAP_A, 3'd2, 1'b1, 6'd1, 6'd12, 6'd2, 2'b10, 3'b010, 35'h43, 35'h41);
    add(2'b10, 1'b1, 3'd2, 3'd2, MAP_A, 3'd3, 1'b1, 6'd0, 6'd11, 6'd3, 2'b10, 3'b010, 35'h1043, 35'h1041);
    add(2'b10, 1'b1, 3'd0, 3'd2, MAP_A, 3'd3, 1'b1, 6'd0, 6'd11, 6'd3, 2'b10, 3'b010, 35'h1043, 35'h1041);
    add(2'b11, 1'b0, 3'd0, 3'd0, MAP_A, 3'd3, 1'b1, 6'd0, 6'd11, 6'd3, 2'b10, 3'b010, 35'h1043, 35'h1041);
    add(2'b01, 1'b0, 3'd0, 3'd0, MAP_A, 3'd1, 1'b0, 6'd0, 6'd11, 6'd3, 2'b10, 3'b000, 35'h1043, 35'h1041);
    add(2'b01, 1'b1, 3'd0, 3'd0, ZERO,  3'd1, 1'b0, 6'd0, 6'd11, 6'd3, 2'b11, 3'b000, 35'h1043, 35'h1041);
    add(2'b10, 1'b0, 3'd0, 3'd0, ZERO,  3'd1, 1'b0, 6'd0, 6'd11, 6'd3, 2'b11, 3'b000, 35'h1043, 35'h1041);
    add(2'b10, 1'b1, 3'd0, 3'd0, ZERO,  3'd1, 1'b0, 6'd0, 6'd11, 6'd3, 2'b11, 3'b000, 35'h1043, 35'h1041);
    add(2'b10, 1'b1, 3'd0, 3'd0, MAP_A, 3'd1, 1'b1, 6'd3, 6'd15, 6'd0, 2'b00, 3'b001, 35'h0, 35'h0);
    add(2'b10, 1'b0, 3'd0, 3'd0, MAP_A, 3'd2, 1'b1, 6'd3, 6'd15, 6'd0, 2'b00, 3'b000, 35'h0, 35'h0);
    add(2'b01, 1'b1, 3'd0, 3'd0, MAP_A, 3'd1, 1'b0, 6'd3, 6'd15, 6'd0, 2'b00, 3'b000, 35'h0, 35'h0);
    add(2'b00, 1'b0, 3'd0, 3'd0, MAP_A, 3'd0, 1'b0, 6'd0, 6'd0,  6'd0, 2'b00, 3'b000, 35'h0, 35'h0);

    repeat (2) @(posedge clock);
    #1;
    chk("reset_estado0", est0, 3'd0);
    chk("reset_estado1", est1, 3'd0);
    chk("reset_estado2", est2, 3'd0);
    chk("reset_outs0", {ok0, tir0, am0, rest0, tr0, ac0, res0, r0, g0, b0}, '0);
    reset_n = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].modo, tbl[k].conf, tbl[k].lin, tbl[k].col, tbl[k].mapa);
      chk($sformatf("v%0d_estado", k), est0, tbl[k].e_est);
      chk($sformatf("v%0d_mapa_ok", k), ok0, tbl[k].e_ok);
      chk($sformatf("v%0d_restantes", k), rest0, tbl[k].e_rest);
      chk($sformatf("v%0d_tiros_rest", k), tr0, tbl[k].e_trest);
      chk($sformatf("v%0d_acertos", k), ac0, tbl[k].e_ac);
      chk($sformatf("v%0d_resultado", k), res0, tbl[k].e_res);
      chk($sformatf("v%0d_rgb", k), {r0, g0, b0}, tbl[k].e_rgb);
      chk($sformatf("v%0d_tiros", k), tir0, tbl[k].e_tiros);
      chk($sformatf("v%0d_acertos_mapa", k), am0, tbl[k].e_am);
    end

    // Shot budgets: one ship at cell 34, then 30 misses on cells 0..29.
    step(2'b01, 1'b0, 3'd0, 3'd0, MAP_B);
    step(2'b01, 1'b1, 3'd0, 3'd0, MAP_B);
    step(2'b10, 1'b0, 3'd0, 3'd0, MAP_B);
    chk("b_trest_max2", tr1, 6'd2);
    chk("b_trest_unlim", tr2, 6'd0);
    chk("b_estado_unlim", est2, 3'd2);
    for (int i = 0; i < 30; i++) begin
      step(2'b10, 1'b1, 3'(i / 5), 3'(i % 5), MAP_B);
      if (i == 1) begin
        chk("b_derrota_estado", est1, 3'd4);
        chk("b_derrota_trest", tr1, 6'd0);
        chk("b_derrota_rgb", {r1, g1, b1}, 3'b100);
      end
    end
    chk("b_max2_hold_estado", est1, 3'd4);
    chk("b_max2_hold_tiros", tir1, 35'h3);
    chk("b_unlim_estado", est2, 3'd2);
    chk("b_unlim_trest", tr2, 6'd0);
    chk("b_unlim_tiros", tir2, 35'h3FFF_FFFF);
    chk("b_unlim_res", res2, 2'b01);
    chk("b_max15_estado", est0, 3'd4);
    chk("b_max15_tiros", tir0, 35'h7FFF);

    // Last shot is also the final hit: victory beats defeat.
    step(2'b01, 1'b0, 3'd0, 3'd0, MAP_C);
    chk("c_prep_estado", est1, 3'd1);
    chk("c_prep_mapa_ok", ok1, 1'b0);
    step(2'b01, 1'b1, 3'd0, 3'd0, MAP_C);
    step(2'b10, 1'b0, 3'd0, 3'd0, MAP_C);
    step(2'b10, 1'b1, 3'd0, 3'd0, MAP_C);
    chk("c_first_hit_trest", tr1, 6'd1);
    chk("c_first_hit_estado", est1, 3'd2);
    step(2'b10, 1'b1, 3'd0, 3'd1, MAP_C);
    chk("c_vitoria_estado", est1, 3'd3);
    chk("c_vitoria_trest", tr1, 6'd0);
    chk("c_vitoria_rgb", {r1, g1, b1}, 3'b010);
    chk("c_vitoria_acertos", ac1, 6'd2);

    // Asynchronous reset in the middle of an attack.
    step(2'b01, 1'b0, 3'd0, 3'd0, MAP_A);
    step(2'b01, 1'b1, 3'd0, 3'd0, MAP_A);
    step(2'b10, 1'b0, 3'd0, 3'd0, MAP_A);
    step(2'b10, 1'b1, 3'd0, 3'd1, MAP_A);
    chk("d_pre_estado", est0, 3'd2);
    chk("d_pre_res", res0, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    chk("d_async_estado0", est0, 3'd0);
    chk("d_async_estado1", est1, 3'd0);
    chk("d_async_outs0", {ok0, tir0, am0, rest0, tr0, ac0, res0, r0, g0, b0}, '0);
    @(negedge clock);
    reset_n = 1'b1;
    step(2'b01, 1'b0, 3'd0, 3'd0, MAP_A);
    chk("d_recover_estado", est0, 3'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
